serial_word_collector: RTL

Downstream stage for the single-bit registered output of the d_flipflop. It consumes a serial bit stream, one bit per qualified clock, and assembles the bits into parallel words. Completed words are presented on a valid/ready output port. A sticky overrun flag reports dropped words. It is the first word-level stage after the bit-level flop.

---
 rtl/serial_word_collector_if.sv | 31 +++
 rtl/serial_word_collector.sv | 116 +++++++++++
 2 files changed

// File: rtl/serial_word_collector_if.sv
// serial_word_collector_if
//   Groups the serial input side (din, din_valid, frame_start), the word
//   output handshake (dout, dout_valid, dout_ready) and the status/control
//   signals (bit_count, overrun, clr_overrun) of the serial word collector.
//   master : the producer of serial bits and consumer of words
//   slave  : the collector itself
interface serial_word_collector_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             din;
    logic             din_valid;
    logic             frame_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [CW-1:0]    bit_count;
    logic             overrun;
    logic             clr_overrun;

    modport master (
        output din, din_valid, frame_start, dout_ready, clr_overrun,
        input  dout, dout_valid, bit_count, overrun
    );

    modport slave (
        input  din, din_valid, frame_start, dout_ready, clr_overrun,
        output dout, dout_valid, bit_count, overrun
    );
endinterface

// File: rtl/serial_word_collector.sv
// serial_word_collector
//   Assembles a serial bit stream (one bit per edge with din_valid=1) into
//   WIDTH-bit words and holds each completed word on a valid/ready port.
//   A completed word arriving while the previous one is still held and not
//   being accepted is dropped and flagged on the sticky overrun output.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, highest priority
//   sif  : slave modport -- din/din_valid/frame_start in, dout/dout_valid out,
//          dout_ready in, bit_count out, overrun out, clr_overrun in
//
// Output-side FSM:
//   state   | meaning
//   --------+--------------------------------------------
//   S_EMPTY | no word held, dout_valid=0
//   S_HELD  | dout holds an unconsumed word, dout_valid=1
module serial_word_collector #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_word_collector_if.slave  sif
);
    localparam int CW = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_word_collector: WIDTH must be in 2..32");
        end
    endgenerate

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_count_q, bit_count_d;
    logic [WIDTH-1:0] dout_q;
    logic             overrun_q;

    logic [WIDTH-1:0] shift_base;
    logic [CW-1:0]    cnt_base;
    logic [WIDTH-1:0] word_d;
    logic             complete;
    logic             drop;

    // frame_start wipes the partial word before the current bit is taken in,
    // so a simultaneous din_valid bit becomes the first bit of a fresh word.
    always_comb begin
        shift_base = sif.frame_start ? '0 : shreg_q;
        cnt_base   = sif.frame_start ? '0 : bit_count_q;
        if (MSB_FIRST) begin
            word_d = {shift_base[WIDTH-2:0], sif.din};
        end else begin
            word_d = {sif.din, shift_base[WIDTH-1:1]};
        end
        complete    = sif.din_valid && !sif.frame_start &&
                      (bit_count_q == CW'(WIDTH - 1));
        drop        = (state_q == S_HELD) && complete && !sif.dout_ready;
        shreg_d     = shift_base;
        bit_count_d = cnt_base;
        if (sif.din_valid) begin
            if (complete) begin
                shreg_d     = '0;
                bit_count_d = '0;
            end else begin
                shreg_d     = word_d;
                bit_count_d = cnt_base + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            shreg_q     <= '0;
            bit_count_q <= '0;
            dout_q      <= '0;
            overrun_q   <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            bit_count_q <= bit_count_d;
            case (state_q)
                S_EMPTY: begin
                    if (complete) begin
                        dout_q  <= word_d;
                        state_q <= S_HELD;
                    end
                end
                S_HELD: begin
                    // A new word only replaces the held one on a transfer edge.
                    if (complete && sif.dout_ready) begin
                        dout_q <= word_d;
                    end else if (!complete && sif.dout_ready) begin
                        state_q <= S_EMPTY;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
            // Setting beats clearing when both happen on the same edge.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (sif.clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign sif.dout       = dout_q;
    assign sif.dout_valid = (state_q == S_HELD);
    assign sif.bit_count  = bit_count_q;
    assign sif.overrun    = overrun_q;
endmodule
